// File: rtl/issue_queue.sv
// Circular issue queue between decode and dispatch: up to two writes and
// two retirements per cycle, with the two oldest entries always presented.
`timescale 1ns/1ps

module issue_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             flush,
  input  logic             in0_valid,
  input  logic [105:0]     in0_payload,
  input  logic             in1_valid,
  input  logic [105:0]     in1_payload,
  output logic             iq_allin,
  input  logic [1:0]       issue_enable,
  output logic [106:0]     inst0_to_dispatch,
  output logic [106:0]     inst1_to_dispatch,
  output logic [PTR_W:0]   iq_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

  logic [105:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [PTR_W:0]   w_free;
  logic             w_allin;
  logic             w_do_push;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_req;
  logic [1:0]       w_pop_n;
  logic [PTR_W-1:0] w_tail1;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W:0]   w_count_next;

  // Admission depends only on registered occupancy so decode never sees a
  // path from dispatch's issue_enable.
  assign w_free    = DEPTH_C - r_count;
  assign w_allin   = (w_free >= TWO_C);
  assign w_do_push = w_allin & ~flush;
  assign w_push_n  = w_do_push ? ({1'b0, in0_valid} + {1'b0, in1_valid}) : 2'd0;
  assign w_tail1   = r_tail + PTR_W'(1);
  assign w_head1   = r_head + PTR_W'(1);

  always_comb begin
    w_pop_req = 2'd0;
    case (issue_enable)
      2'b01:   w_pop_req = 2'd1;
      2'b10:   w_pop_req = 2'd2;
      default: w_pop_req = 2'd0;
    endcase
  end

  // Requests beyond the current occupancy are clipped (count < 2 here).
  always_comb begin
    w_pop_n = w_pop_req;
    if (r_count < (PTR_W+1)'(w_pop_req)) begin
      w_pop_n = r_count[1:0];
    end
  end

  assign w_count_next = r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= w_count_next;
    end
  end

  // Entry storage is not reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      if (in0_valid) begin
        r_mem[r_tail] <= in0_payload;
      end
      if (in1_valid) begin
        r_mem[in0_valid ? w_tail1 : r_tail] <= in1_payload;
      end
    end
  end

  assign iq_allin          = w_allin;
  assign iq_count          = r_count;
  assign inst0_to_dispatch = (r_count > (PTR_W+1)'(0)) ? {r_mem[r_head],  1'b1} : '0;
  assign inst1_to_dispatch = (r_count > (PTR_W+1)'(1)) ? {r_mem[w_head1], 1'b1} : '0;

endmodule
